// File: rtl/avalon_loader_pkg.sv
// Shared types and default widths for the Avalon-MM RAM loader.
package avalon_loader_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LEN_W        = 11;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  localparam logic [DEF_DATA_W/8-1:0] BE_ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/loader_sync_fifo.sv
// Small synchronous FIFO holding read-return data; pop_data shows the head entry.
module loader_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push while full is only allowed when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; validity is defined only by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/avalon_mm_ram_loader.sv
// Avalon-MM master that block-fills or block-dumps a fixed-latency on-chip RAM.
// Optional running checksum output enabled by defining LOADER_CHECKSUM_EN.
module avalon_mm_ram_loader
  import avalon_loader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_debugaccess,
  output logic                avm_clken,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        rem_q;
  logic [CNT_W-1:0]        inflight_q;
  logic [CNT_W-1:0]        fifo_count;
  logic [READ_LATENCY-1:0] vld_sr;
  logic                    cmd_fire;
  logic                    wr_beat;
  logic                    rd_accept;
  logic                    rd_push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    credit_ok;
  logic                    last_word;

  assign cmd_fire  = (state == IDLE) && cmd_valid;
  assign last_word = (rem_q == LEN_W'(1));

  // Credits count both buffered words and reads still in the slave pipeline.
  assign credit_ok = !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH));

  assign in_ready  = (state == WRITE) && !avm_waitrequest;
  assign avm_write = (state == WRITE) && in_valid;
  assign wr_beat   = avm_write && !avm_waitrequest;
  assign avm_read  = (state == READ) && (rem_q != '0) && credit_ok;
  assign rd_accept = avm_read && !avm_waitrequest;
  assign rd_push   = vld_sr[READ_LATENCY-1];

  assign avm_address     = addr_q;
  assign avm_chipselect  = avm_read || avm_write;
  assign avm_debugaccess = avm_write;
  assign avm_byteenable  = {(DATA_W/8){1'b1}};
  assign avm_clken       = 1'b1;
  assign avm_writedata   = in_data;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_len == '0) state_nxt = DONE;
          else if (cmd_write) state_nxt = WRITE;
          else state_nxt = READ;
        end
      end
      WRITE: if (wr_beat && last_word) state_nxt = DONE;
      READ:  if (rd_accept && last_word) state_nxt = DRAIN;
      DRAIN: if ((inflight_q == '0) && fifo_empty) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      vld_sr     <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (wr_beat || rd_accept) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      vld_sr[0] <= rd_accept;
      for (int i = 1; i < READ_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
      case ({rd_accept, rd_push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;

  loader_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_push),
    .push_data (avm_readdata),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Write beats and stream pops never coincide: the FIFO only fills during reads.
  always_ff @(posedge clk) begin
    if (reset || cmd_fire) sum_q <= '0;
    else if (wr_beat)      sum_q <= sum_q + in_data;
    else if (fifo_pop)     sum_q <= sum_q + out_data;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_avalon_mm_ram_loader.sv
// Directed bench for avalon_mm_ram_loader with a fixed-latency RAM slave and scoreboard queues.
module tb_avalon_mm_ram_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_debugaccess;
  logic        avm_clken;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] exp_sum;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int bus_act     = 0;
  int acc         = 0;
  int del         = 0;
  int first_pop   = -1;
  int last_pop    = -1;

  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] ref_mem [1024];
  logic [31:0] ram [1024];

  avalon_mm_ram_loader dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .busy            (busy),
    .done            (done),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
`ifdef LOADER_CHECKSUM_EN
    .checksum        (checksum),
`endif
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_debugaccess (avm_debugaccess),
    .avm_clken       (avm_clken),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM slave with one cycle of read latency.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write && !avm_waitrequest) ram[avm_address] <= avm_writedata;
    if (avm_chipselect && avm_read && !avm_waitrequest) avm_readdata <= ram[avm_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: scoreboard writes and stream pops, bound the outstanding reads.
  always @(negedge clk) begin
    wr_t         e;
    logic [31:0] r;
    cyc++;
    if (avm_read || avm_write) bus_act++;
    if (avm_write && !avm_waitrequest) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", {54'd0, avm_address}, 64'hFFFF);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", {54'd0, avm_address}, {54'd0, e.addr});
        chk("wr_data", {32'd0, avm_writedata}, {32'd0, e.data});
        chk("wr_debugaccess", {63'd0, avm_debugaccess}, 64'd1);
        chk("wr_byteenable", {60'd0, avm_byteenable}, 64'hF);
        chk("wr_chipselect", {63'd0, avm_chipselect}, 64'd1);
      end
    end
    if (avm_read && !avm_waitrequest) begin
      acc++;
      chk("outstanding_le_depth", {63'd0, (acc - del) <= 4}, 64'd1);
    end
    if (out_valid && out_ready) begin
      del++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (exp_rd.size() == 0) begin
        chk("unexpected_out", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF);
      end else begin
        r = exp_rd.pop_front();
        chk("rd_data", {32'd0, out_data}, {32'd0, r});
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [10:0] n);
    int k;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = n;
    cmd_valid = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("cmd_accept_timeout", {63'd0, k < 20}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // exp_lat > 0 demands done on exactly that negedge after the call.
  task automatic wait_done(input int exp_lat);
    int k;
    @(negedge clk);
    k = 1;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    if (exp_lat > 0) chk("done_latency", 64'(k), 64'(exp_lat));
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_after_done", {62'd0, cmd_ready, busy}, 64'b10);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", {32'd0, checksum}, {32'd0, exp_sum});
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input int n, input int stall_at,
                          input logic [31:0] base, input logic [31:0] step);
    logic [9:0]  ai;
    logic [31:0] d;
    int          k;
    send_cmd(1'b1, a, 11'(n));
    for (int i = 0; i < n; i++) begin
      ai = a + 10'(i);
      d  = base + 32'(i) * step;
      in_valid = 1'b1;
      in_data  = d;
      exp_wr.push_back('{addr: ai, data: d});
      ref_mem[ai] = d;
`ifdef LOADER_CHECKSUM_EN
      exp_sum = exp_sum + d;
`endif
      if (i == stall_at) begin
        avm_waitrequest = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
          chk("stall_addr", {54'd0, avm_address}, {54'd0, ai});
          chk("stall_wdata", {32'd0, avm_writedata}, {32'd0, d});
          @(posedge clk);
          #1;
        end
        avm_waitrequest = 1'b0;
      end
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
        k++;
        @(negedge clk);
      end
      chk("beat_timeout", {63'd0, k < 20}, 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_done(1);
  endtask

  task automatic do_read(input logic [9:0] a, input int n, input int hold);
    logic [9:0] ai;
    out_ready = (hold == 0);
    acc = 0;
    del = 0;
    first_pop = -1;
    last_pop  = -1;
    send_cmd(1'b0, a, 11'(n));
    for (int i = 0; i < n; i++) begin
      ai = a + 10'(i);
      exp_rd.push_back(ref_mem[ai]);
`ifdef LOADER_CHECKSUM_EN
      exp_sum = exp_sum + ref_mem[ai];
`endif
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    wait_done(0);
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    chk("rd_accepted", 64'(acc), 64'(n));
    chk("rd_delivered", 64'(del), 64'(n));
  endtask

  initial begin
    int b0;
    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_addr        = '0;
    cmd_len         = '0;
    in_valid        = 1'b0;
    in_data         = '0;
    out_ready       = 1'b0;
    avm_waitrequest = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_streams", {62'd0, in_ready, out_valid}, 64'd0);
    chk("rst_bus_ctl", {61'd0, avm_read, avm_write, avm_chipselect}, 64'd0);
    chk("rst_address", {54'd0, avm_address}, 64'd0);
    chk("rst_be_clken", {59'd0, avm_byteenable, avm_clken}, 64'h1F);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill 0..3 with 0x11111111..0x44444444.
    do_write(10'd0, 4, -1, 32'h1111_1111, 32'h1111_1111);

    // Read back; in_valid held high outside WRITE must not cause bus writes.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    do_read(10'd0, 4, 0);
    in_valid = 1'b0;
    chk("rd4_consecutive", 64'(last_pop - first_pop), 64'd3);

    // Fill across the top of memory: 1022, 1023, 0, 1.
    do_write(10'd1022, 4, -1, 32'hA000_0000, 32'h0000_0001);

    // Three waitrequest cycles on the third beat.
    do_write(10'd4, 6, 2, 32'hC0DE_0000, 32'h0000_0101);

    // Backpressure: eight words with out_ready low for six cycles.
    do_read(10'd0, 8, 6);

    // Zero-length command: done only, no bus activity.
    b0 = bus_act;
    send_cmd(1'b0, 10'd5, 11'd0);
    wait_done(1);
    chk("len0_no_bus", 64'(bus_act), 64'(b0));

    // Reset in the middle of a read aborts it without a done pulse.
    out_ready = 1'b0;
    acc = 0;
    del = 0;
    send_cmd(1'b0, 10'd0, 11'd8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", {62'd0, cmd_ready, busy}, 64'b10);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_avm_read", {63'd0, avm_read}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("abort_checksum", {32'd0, checksum}, 64'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", {62'd0, done, out_valid}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Recovery after abort, reading across the top of memory.
    do_read(10'd1022, 2, 0);

    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
